// File: rtl/ad9643_pkg.sv
// Shared types and helpers for the AD9643 capture path: FSM state encoding,
// native ADC sample width and the two-channel stream word packing.
package ad9643_pkg;

  localparam int ADC_SMP_W = 14;

  typedef enum logic [2:0] {
    RST,
    WAIT_RDY,
    ARMED,
    CAPTURE,
    STOP
  } cap_state_t;

  // Each channel is zero-extended to a 16-bit lane, channel B in the upper half.
  function automatic logic [31:0] pack_ab(input logic [ADC_SMP_W-1:0] a,
                                          input logic [ADC_SMP_W-1:0] b);
    return {{(16-ADC_SMP_W){1'b0}}, b, {(16-ADC_SMP_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/ad9643_sync2.sv
// Two-flop synchroniser bringing the IDELAYCTRL ready flag into the capture clock domain.
module ad9643_sync2 (
  input  logic aclk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/ad9643_capture_ctrl.sv
// AD9643 capture sequencer: DDR input-stage reset / IDELAY lock handling and
// framing of the dual-channel sample stream into fixed-length AXI-Stream packets.
module ad9643_capture_ctrl
  import ad9643_pkg::*;
#(
  parameter int SMP_W      = ADC_SMP_W,
  parameter int RST_CYCLES = 16,
  parameter int LEN_W      = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cfg_ddr_reset,
  input  logic             cfg_data_en,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic             delay_rdy,
  output logic             ddr_rst_o,
  input  logic [SMP_W-1:0] adc_a,
  input  logic [SMP_W-1:0] adc_b,
  input  logic             adc_valid,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sts_ready,
  output logic             sts_overflow,
  output logic [LEN_W-1:0] sts_frames
);

  localparam int RC_W = $clog2(RST_CYCLES);

  cap_state_t       state_reg;
  logic [RC_W-1:0]  rst_cnt_reg;
  logic [LEN_W-1:0] smp_cnt_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] frames_reg;
  logic [31:0]      tdata_reg;
  logic             tvalid_reg;
  logic             tlast_reg;
  logic             ddr_rst_reg;
  logic             ready_reg;
  logic             ovf_reg;
  logic             ddr_req_d_reg;
  logic             rdy_sync;

  logic             ddr_req_rise;
  logic             lock_lost;
  logic             in_capture;
  logic             stop_now;
  logic             can_load;
  logic             load;
  logic             drop;
  logic             is_last;
  logic [LEN_W-1:0] cfg_len_eff;

  ad9643_sync2 u_rdy_sync (
    .aclk   (aclk),
    .areset (areset),
    .d      (delay_rdy),
    .q      (rdy_sync)
  );

  assign ddr_req_rise = cfg_ddr_reset & ~ddr_req_d_reg;
  assign lock_lost    = ((state_reg == ARMED) || (state_reg == CAPTURE)) && !rdy_sync;
  assign in_capture   = (state_reg == CAPTURE);
  assign cfg_len_eff  = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
  // Enable removed on a packet boundary: nothing to truncate, stop without emitting.
  assign stop_now     = in_capture && !cfg_data_en && (smp_cnt_reg == '0);
  assign can_load     = !tvalid_reg || m_axis_tready;
  assign load         = in_capture && !stop_now && adc_valid && can_load;
  assign drop         = in_capture && !stop_now && adc_valid && !can_load;
  assign is_last      = (smp_cnt_reg == len_reg - 1'b1) || !cfg_data_en;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg     <= RST;
      rst_cnt_reg   <= '0;
      smp_cnt_reg   <= '0;
      len_reg       <= LEN_W'(1);
      frames_reg    <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      ddr_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      ddr_req_d_reg <= 1'b0;
    end else begin
      ddr_req_d_reg <= cfg_ddr_reset;
      if (ddr_req_rise || lock_lost) begin
        // Pending beat is discarded outright; a register request clears the
        // sticky overflow while a lock loss flags it.
        state_reg   <= RST;
        rst_cnt_reg <= '0;
        ddr_rst_reg <= 1'b1;
        ready_reg   <= 1'b0;
        tvalid_reg  <= 1'b0;
        tlast_reg   <= 1'b0;
        smp_cnt_reg <= '0;
        ovf_reg     <= lock_lost && !ddr_req_rise;
      end else begin
        if (load) begin
          tdata_reg  <= pack_ab(adc_a, adc_b);
          tvalid_reg <= 1'b1;
          tlast_reg  <= is_last;
          if (is_last) begin
            smp_cnt_reg <= '0;
            frames_reg  <= frames_reg + 1'b1;
            len_reg     <= cfg_len_eff;
          end else begin
            smp_cnt_reg <= smp_cnt_reg + 1'b1;
          end
        end else if (m_axis_tready) begin
          tvalid_reg <= 1'b0;
        end
        if (drop) begin
          ovf_reg <= 1'b1;
        end

        case (state_reg)
          RST: begin
            if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
              state_reg   <= WAIT_RDY;
              ddr_rst_reg <= 1'b0;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end
          end
          WAIT_RDY: begin
            if (rdy_sync) begin
              state_reg <= ARMED;
              ready_reg <= 1'b1;
            end
          end
          ARMED: begin
            if (cfg_data_en) begin
              state_reg   <= CAPTURE;
              smp_cnt_reg <= '0;
              len_reg     <= cfg_len_eff;
            end
          end
          CAPTURE: begin
            if (stop_now || (load && !cfg_data_en)) begin
              state_reg <= STOP;
              ready_reg <= 1'b0;
            end
          end
          STOP: begin
            if (!tvalid_reg) begin
              state_reg <= ARMED;
              ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= RST;
          end
        endcase
      end
    end
  end

  assign ddr_rst_o     = ddr_rst_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign sts_ready     = ready_reg;
  assign sts_overflow  = ovf_reg;
  assign sts_frames    = frames_reg;

endmodule

// File: tb/tb_ad9643_capture_ctrl.sv
// Self-checking bench for ad9643_capture_ctrl: vector table of packet runs plus
// hand-written reset, back-pressure, truncation, lock-loss and async-reset sequences.
module tb_ad9643_capture_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_ddr_reset;
  logic        cfg_data_en;
  logic [15:0] cfg_frame_len;
  logic        delay_rdy;
  logic        ddr_rst_o;
  logic [13:0] adc_a;
  logic [13:0] adc_b;
  logic        adc_valid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        sts_ready;
  logic        sts_overflow;
  logic [15:0] sts_frames;

  ad9643_capture_ctrl dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_ddr_reset (cfg_ddr_reset),
    .cfg_data_en   (cfg_data_en),
    .cfg_frame_len (cfg_frame_len),
    .delay_rdy     (delay_rdy),
    .ddr_rst_o     (ddr_rst_o),
    .adc_a         (adc_a),
    .adc_b         (adc_b),
    .adc_valid     (adc_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_ready     (sts_ready),
    .sts_overflow  (sts_overflow),
    .sts_frames    (sts_frames)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int len;
    int n;
    int a0;
    int b0;
    int frames_delta;
  } vec_t;

  beat_t       q[$];
  vec_t        vecs[5];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_frames = '0;

  function automatic logic [31:0] tb_pack(input logic [13:0] a, input logic [13:0] b);
    return {2'b00, b, 2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Consume the beat handshaken at the coming edge, then advance one cycle.
  task automatic tick();
    beat_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %h last=%0b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        e = q.pop_front();
        $display("[TB] beat data=%h last=%0b (expect %h/%0b)", m_axis_tdata, m_axis_tlast, e.data, e.last);
        chk("beat_data", m_axis_tdata, e.data);
        chk("beat_last", {31'b0, m_axis_tlast}, {31'b0, e.last});
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_sample(input logic [13:0] a, input logic [13:0] b);
    adc_a     = a;
    adc_b     = b;
    adc_valid = 1'b1;
  endtask

  task automatic push(input logic [13:0] a, input logic [13:0] b, input logic last);
    beat_t e;
    e.data = tb_pack(a, b);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic to_armed();
    adc_valid   = 1'b0;
    cfg_data_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic count_ddr_rst(input string name);
    int n = 0;
    while (ddr_rst_o && n < 40) begin
      n++;
      tick();
    end
    chk(name, n, 16);
  endtask

  task automatic run_vec(input vec_t v);
    int eff;
    logic [13:0] a;
    logic [13:0] b;
    eff = (v.len == 0) ? 1 : v.len;
    cfg_frame_len = 16'(v.len);
    cfg_data_en   = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    for (int i = 0; i < v.n; i++) begin
      a = 14'(v.a0 + i);
      b = 14'(v.b0 + i);
      drive_sample(a, b);
      push(a, b, ((i + 1) % eff) == 0);
      tick();
      if (i == 0) chk("first_tdata", m_axis_tdata, tb_pack(a, b));
    end
    adc_valid = 1'b0;
    tick();
    tick();
    exp_frames += 16'(v.frames_delta);
    chk("vec_frames", sts_frames, exp_frames);
    chk("vec_sb_empty", q.size(), 0);
    to_armed();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 8, 'h0001, 'h2000, 2};
    vecs[1] = '{1, 3, 'h3FFF, 'h0000, 3};
    vecs[2] = '{0, 2, 'h0AAA, 'h1555, 2};
    vecs[3] = '{3, 6, 'h0100, 'h3F00, 2};
    vecs[4] = '{5, 5, 'h1234, 'h0321, 1};

    areset        = 1'b1;
    cfg_ddr_reset = 1'b0;
    cfg_data_en   = 1'b0;
    cfg_frame_len = 16'd4;
    delay_rdy     = 1'b0;
    adc_a         = '0;
    adc_b         = '0;
    adc_valid     = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    chk("rst_ddr_rst", ddr_rst_o, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_ready", sts_ready, 0);
    chk("rst_ovf", sts_overflow, 0);
    chk("rst_frames", sts_frames, 0);

    // Power-up reset sequence and ready synchronisation.
    areset = 1'b0;
    count_ddr_rst("powerup_ddr_rst_cycles");
    delay_rdy = 1'b1;
    tick();
    tick();
    chk("ready_before_sync", sts_ready, 0);
    tick();
    chk("ready_after_sync", sts_ready, 1);

    // Packet runs, one per table entry.
    foreach (vecs[k]) run_vec(vecs[k]);

    // Back-pressure mid-packet: three samples dropped, tlast on 4th delivered beat.
    cfg_frame_len = 16'd4;
    cfg_data_en   = 1'b1;
    tick();
    drive_sample(14'h0011, 14'h0101); push(14'h0011, 14'h0101, 1'b0); tick();
    drive_sample(14'h0012, 14'h0102); push(14'h0012, 14'h0102, 1'b0); tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_sample(14'(16'h0013 + i), 14'(16'h0103 + i));
      tick();
      chk("bp_tdata_held", m_axis_tdata, tb_pack(14'h0012, 14'h0102));
    end
    m_axis_tready = 1'b1;
    drive_sample(14'h0016, 14'h0106); push(14'h0016, 14'h0106, 1'b0); tick();
    drive_sample(14'h0017, 14'h0107); push(14'h0017, 14'h0107, 1'b1); tick();
    adc_valid = 1'b0;
    tick();
    tick();
    exp_frames += 16'd1;
    chk("bp_overflow", sts_overflow, 1);
    chk("bp_frames", sts_frames, exp_frames);
    chk("bp_sb_empty", q.size(), 0);
    to_armed();

    // Enable removed after sample 2 of len=8: sample 3 closes the packet.
    cfg_frame_len = 16'd8;
    cfg_data_en   = 1'b1;
    tick();
    drive_sample(14'h0021, 14'h0201); push(14'h0021, 14'h0201, 1'b0); tick();
    drive_sample(14'h0022, 14'h0202); push(14'h0022, 14'h0202, 1'b0); tick();
    cfg_data_en = 1'b0;
    drive_sample(14'h0023, 14'h0203); push(14'h0023, 14'h0203, 1'b1); tick();
    chk("trunc_tlast", m_axis_tlast, 1);
    chk("trunc_stop_ready", sts_ready, 0);
    drive_sample(14'h0024, 14'h0204);
    tick();
    tick();
    chk("trunc_armed_ready", sts_ready, 1);
    chk("trunc_no_extra_beat", m_axis_tvalid, 0);
    adc_valid = 1'b0;
    exp_frames += 16'd1;
    chk("trunc_frames", sts_frames, exp_frames);
    chk("trunc_sb_empty", q.size(), 0);

    // Reset request mid-packet under back-pressure.
    cfg_frame_len = 16'd4;
    cfg_data_en   = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    drive_sample(14'h0031, 14'h0301); tick();
    drive_sample(14'h0032, 14'h0302); tick();
    adc_valid     = 1'b0;
    cfg_data_en   = 1'b0;
    cfg_ddr_reset = 1'b1;
    tick();
    cfg_ddr_reset = 1'b0;
    chk("ddrreq_tvalid", m_axis_tvalid, 0);
    chk("ddrreq_ovf_cleared", sts_overflow, 0);
    chk("ddrreq_frames", sts_frames, exp_frames);
    chk("ddrreq_ready", sts_ready, 0);
    count_ddr_rst("ddrreq_ddr_rst_cycles");
    tick();
    tick();
    chk("ddrreq_rearmed", sts_ready, 1);
    // Samples while ARMED are ignored and never flag overflow.
    drive_sample(14'h0040, 14'h0400);
    repeat (3) tick();
    chk("armed_ignore_ovf", sts_overflow, 0);
    chk("armed_ignore_tvalid", m_axis_tvalid, 0);
    adc_valid     = 1'b0;
    m_axis_tready = 1'b1;

    // Lock loss while capturing.
    cfg_frame_len = 16'd4;
    cfg_data_en   = 1'b1;
    tick();
    delay_rdy = 1'b0;
    tick();
    tick();
    chk("lock_ddr_rst_before", ddr_rst_o, 0);
    tick();
    chk("lock_ddr_rst", ddr_rst_o, 1);
    chk("lock_ovf", sts_overflow, 1);
    delay_rdy     = 1'b1;
    cfg_frame_len = 16'd1;
    begin
      int n = 0;
      while (!sts_ready && n < 60) begin
        n++;
        tick();
      end
    end
    chk("lock_relock", sts_ready, 1);
    tick();

    // Asynchronous reset mid-capture with a held tlast beat.
    m_axis_tready = 1'b0;
    drive_sample(14'h0051, 14'h0501); tick();
    drive_sample(14'h0052, 14'h0502); tick();
    adc_valid = 1'b0;
    exp_frames += 16'd1;
    chk("pre_areset_tlast", m_axis_tlast, 1);
    chk("pre_areset_frames", sts_frames, exp_frames);
    #2;
    areset = 1'b1;
    #1;
    chk("areset_ddr_rst", ddr_rst_o, 1);
    chk("areset_tvalid", m_axis_tvalid, 0);
    chk("areset_tlast", m_axis_tlast, 0);
    chk("areset_tdata", m_axis_tdata, 0);
    chk("areset_ready", sts_ready, 0);
    chk("areset_ovf", sts_overflow, 0);
    chk("areset_frames", sts_frames, 0);
    #2;
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    exp_frames    = '0;
    tick();
    chk("final_sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
